// File: rtl/alu_op_dispatch.sv
// ============================================================================
// Module   : alu_op_dispatch
// Purpose  : FIFO-buffered ALU issue stage with credit-limited in-flight count.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_op_dispatch #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int MAX_OUTST  = 2
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          REQ_VLD,
    output logic                          REQ_RDY,
    input  logic [3:0]                    REQ_OP,
    input  logic [1:0]                    REQ_MOVI,
    input  logic [DATA_WIDTH-1:0]         REQ_A,
    input  logic [DATA_WIDTH-1:0]         REQ_B,
    input  logic [DATA_WIDTH-1:0]         REQ_MEM,
    input  logic [DATA_WIDTH-1:0]         REQ_IMM,
    input  logic                          ALU_RDY,
    input  logic                          EX_ALU_VLD,
    output logic                          ACT,
    output logic [3:0]                    OP,
    output logic [1:0]                    MOVI,
    output logic [DATA_WIDTH-1:0]         REG_A,
    output logic [DATA_WIDTH-1:0]         REG_B,
    output logic [DATA_WIDTH-1:0]         MEM,
    output logic [DATA_WIDTH-1:0]         IMM,
    output logic [$clog2(DEPTH):0]        FIFO_CNT,
    output logic [$clog2(MAX_OUTST):0]    OUTST,
    output logic                          CRED_ERR
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_OUT_W = $clog2(MAX_OUTST) + 1;
    localparam int c_ENT_W = 4 + 2 + 4 * DATA_WIDTH;

    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);
    localparam logic [c_OUT_W-1:0] c_MAX   = c_OUT_W'(MAX_OUTST);

    logic [c_ENT_W-1:0] r_mem_q    [DEPTH];
    logic [c_ENT_W-1:0] w_mem_d    [DEPTH];
    logic [c_PTR_W-1:0] r_wptr_q, w_wptr_d;
    logic [c_PTR_W-1:0] r_rptr_q, w_rptr_d;
    logic [c_CNT_W-1:0] r_cnt_q,  w_cnt_d;
    logic [c_OUT_W-1:0] r_out_q,  w_out_d;
    logic               r_err_q,  w_err_d;

    logic               w_push;
    logic               w_pop;
    logic [c_ENT_W-1:0] w_head;

    assign REQ_RDY = !RST && (r_cnt_q < c_DEPTH);
    assign ACT     = !RST && (r_cnt_q != '0) && ALU_RDY && (r_out_q < c_MAX);
    assign w_push  = REQ_VLD && REQ_RDY;
    assign w_pop   = ACT;

    // Outputs always reflect the stored head slot; no bypass from the request port.
    assign w_head = r_mem_q[r_rptr_q];
    assign {OP, MOVI, REG_A, REG_B, MEM, IMM} = w_head;

    assign FIFO_CNT = r_cnt_q;
    assign OUTST    = r_out_q;
    assign CRED_ERR = r_err_q;

    always_comb begin
        w_mem_d  = r_mem_q;
        w_wptr_d = r_wptr_q;
        w_rptr_d = r_rptr_q;
        w_cnt_d  = r_cnt_q;
        w_out_d  = r_out_q;
        w_err_d  = r_err_q;

        if (w_push) begin
            w_mem_d[r_wptr_q] = {REQ_OP, REQ_MOVI, REQ_A, REQ_B, REQ_MEM, REQ_IMM};
            w_wptr_d          = r_wptr_q + 1'b1;
        end
        if (w_pop) begin
            w_rptr_d = r_rptr_q + 1'b1;
        end

        if (w_push && !w_pop) begin
            w_cnt_d = r_cnt_q + 1'b1;
        end else if (!w_push && w_pop) begin
            w_cnt_d = r_cnt_q - 1'b1;
        end

        // A return with nothing outstanding is flagged but never underflows the count.
        if (w_pop && !EX_ALU_VLD) begin
            w_out_d = r_out_q + 1'b1;
        end else if (!w_pop && EX_ALU_VLD && (r_out_q != '0)) begin
            w_out_d = r_out_q - 1'b1;
        end
        if (EX_ALU_VLD && (r_out_q == '0)) begin
            w_err_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_q[i] <= '0;
            end
            r_wptr_q <= '0;
            r_rptr_q <= '0;
            r_cnt_q  <= '0;
            r_out_q  <= '0;
            r_err_q  <= 1'b0;
        end else begin
            r_mem_q  <= w_mem_d;
            r_wptr_q <= w_wptr_d;
            r_rptr_q <= w_rptr_d;
            r_cnt_q  <= w_cnt_d;
            r_out_q  <= w_out_d;
            r_err_q  <= w_err_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_op_dispatch.sv
// ============================================================================
// Module   : tb_alu_op_dispatch
// Purpose  : Directed and randomized checks of alu_op_dispatch against a queue model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_op_dispatch;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int MAXO  = 2;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          REQ_VLD = 1'b0;
    logic          REQ_RDY;
    logic [3:0]    REQ_OP = '0;
    logic [1:0]    REQ_MOVI = '0;
    logic [DW-1:0] REQ_A = '0, REQ_B = '0, REQ_MEM = '0, REQ_IMM = '0;
    logic          ALU_RDY = 1'b0;
    logic          EX_ALU_VLD = 1'b0;
    logic          ACT;
    logic [3:0]    OP;
    logic [1:0]    MOVI;
    logic [DW-1:0] REG_A, REG_B, MEM, IMM;
    logic [2:0]    FIFO_CNT;
    logic [1:0]    OUTST;
    logic          CRED_ERR;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0]    op;
        logic [1:0]    movi;
        logic [DW-1:0] a, b, mem, imm;
    } ent_t;

    ent_t q[$];
    int   m_out = 0;
    bit   m_err = 1'b0;

    alu_op_dispatch #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .MAX_OUTST(MAXO)) dut (
        .CLK(CLK), .RST(RST), .REQ_VLD(REQ_VLD), .REQ_RDY(REQ_RDY),
        .REQ_OP(REQ_OP), .REQ_MOVI(REQ_MOVI), .REQ_A(REQ_A), .REQ_B(REQ_B),
        .REQ_MEM(REQ_MEM), .REQ_IMM(REQ_IMM), .ALU_RDY(ALU_RDY),
        .EX_ALU_VLD(EX_ALU_VLD), .ACT(ACT), .OP(OP), .MOVI(MOVI),
        .REG_A(REG_A), .REG_B(REG_B), .MEM(MEM), .IMM(IMM),
        .FIFO_CNT(FIFO_CNT), .OUTST(OUTST), .CRED_ERR(CRED_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: compare then advance at every falling edge.
    always @(negedge CLK) begin
        bit e_rdy, e_act;
        e_rdy = !RST && (q.size() < DEPTH);
        e_act = !RST && (q.size() > 0) && ALU_RDY && (m_out < MAXO);
        chk("m_rdy",  32'(REQ_RDY),  32'(e_rdy));
        chk("m_act",  32'(ACT),      32'(e_act));
        chk("m_cnt",  32'(FIFO_CNT), q.size());
        chk("m_outst", 32'(OUTST),   m_out);
        chk("m_err",  32'(CRED_ERR), 32'(m_err));
        if (q.size() > 0) begin
            chk("m_op",   32'(OP),    32'(q[0].op));
            chk("m_movi", 32'(MOVI),  32'(q[0].movi));
            chk("m_a",    32'(REG_A), 32'(q[0].a));
            chk("m_b",    32'(REG_B), 32'(q[0].b));
            chk("m_mem",  32'(MEM),   32'(q[0].mem));
            chk("m_imm",  32'(IMM),   32'(q[0].imm));
        end
        if (RST) begin
            q.delete();
            m_out = 0;
            m_err = 1'b0;
        end else begin
            if (EX_ALU_VLD && m_out == 0) m_err = 1'b1;
            if (e_act && !EX_ALU_VLD) m_out++;
            else if (!e_act && EX_ALU_VLD && m_out > 0) m_out--;
            if (e_act) void'(q.pop_front());
            if (REQ_VLD && e_rdy) begin
                ent_t e;
                e.op = REQ_OP; e.movi = REQ_MOVI; e.a = REQ_A;
                e.b = REQ_B; e.mem = REQ_MEM; e.imm = REQ_IMM;
                q.push_back(e);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int exp_a;
        int guard;
        bit accepted;
        bit fired;

        // Reset state
        repeat (3) tick();
        RST = 1'b0;
        #1;
        chk("rst_rdy",   32'(REQ_RDY),  32'd1);
        chk("rst_cnt",   32'(FIFO_CNT), 32'd0);
        chk("rst_outst", 32'(OUTST),    32'd0);
        chk("rst_err",   32'(CRED_ERR), 32'd0);
        chk("rst_rega",  32'(REG_A),    32'd0);

        // Single push: issue exactly one cycle after the accept edge
        REQ_VLD = 1'b1; REQ_OP = 4'h1; REQ_MOVI = 2'd0;
        REQ_A = 8'h12; REQ_B = 8'h34; REQ_MEM = 8'h00; REQ_IMM = 8'h00;
        ALU_RDY = 1'b1;
        #1;
        chk("single_act_before", 32'(ACT), 32'd0);
        tick();
        REQ_VLD = 1'b0;
        #1;
        chk("single_act",  32'(ACT),   32'd1);
        chk("single_rega", 32'(REG_A), 32'h12);
        chk("single_regb", 32'(REG_B), 32'h34);
        chk("single_op",   32'(OP),    32'h1);
        tick();
        chk("single_outst1", 32'(OUTST), 32'd1);
        chk("single_act_after", 32'(ACT), 32'd0);
        EX_ALU_VLD = 1'b1;
        tick();
        EX_ALU_VLD = 1'b0;
        #1;
        chk("single_outst0", 32'(OUTST),    32'd0);
        chk("single_noerr",  32'(CRED_ERR), 32'd0);

        // Spurious credit return sets the sticky error
        ALU_RDY = 1'b0;
        EX_ALU_VLD = 1'b1;
        tick();
        EX_ALU_VLD = 1'b0;
        #1;
        chk("cred_err",       32'(CRED_ERR), 32'd1);
        chk("cred_err_outst", 32'(OUTST),    32'd0);
        repeat (3) tick();
        chk("cred_err_sticky", 32'(CRED_ERR), 32'd1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        #1;
        chk("cred_err_clear", 32'(CRED_ERR), 32'd0);

        // Fill to full with the ALU stalled, then drain in order
        for (int i = 1; i <= 4; i++) begin
            REQ_VLD = 1'b1; REQ_A = 8'(i); REQ_OP = 4'(i); REQ_B = 8'(i + 16);
            tick();
        end
        REQ_A = 8'd5; REQ_OP = 4'd5; REQ_B = 8'd21;
        #1;
        chk("full_cnt", 32'(FIFO_CNT), 32'd4);
        chk("full_rdy", 32'(REQ_RDY),  32'd0);
        ALU_RDY = 1'b1;
        exp_a = 1;
        guard = 0;
        while (exp_a <= 5 && guard < 100) begin
            guard++;
            #1;
            if (ACT) begin
                chk("drain_order", 32'(REG_A), 32'(exp_a));
                exp_a++;
            end
            accepted = REQ_VLD && REQ_RDY;
            fired = ACT;
            tick();
            if (accepted) REQ_VLD = 1'b0;
            EX_ALU_VLD = fired;
        end
        if (exp_a <= 5) chk("drain_timeout", 32'(exp_a), 32'd6);
        tick();
        EX_ALU_VLD = 1'b0;
        tick();

        // Credit stall at MAX_OUTST, single return re-enables issue
        RST = 1'b1;
        tick();
        RST = 1'b0;
        ALU_RDY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            REQ_VLD = 1'b1; REQ_A = 8'(8'h21 + i);
            tick();
        end
        REQ_VLD = 1'b0;
        ALU_RDY = 1'b1;
        tick();
        tick();
        chk("stall_outst", 32'(OUTST),    32'd2);
        chk("stall_act",   32'(ACT),      32'd0);
        chk("stall_cnt",   32'(FIFO_CNT), 32'd1);
        tick();
        chk("stall_hold", 32'(ACT), 32'd0);
        EX_ALU_VLD = 1'b1;
        #1;
        chk("stall_no_reuse", 32'(ACT), 32'd0);
        tick();
        EX_ALU_VLD = 1'b0;
        #1;
        chk("stall_resume_act", 32'(ACT),   32'd1);
        chk("stall_resume_a",   32'(REG_A), 32'h23);
        chk("stall_resume_out", 32'(OUTST), 32'd1);
        tick();
        chk("stall_final_out", 32'(OUTST),    32'd2);
        chk("stall_final_cnt", 32'(FIFO_CNT), 32'd0);

        // Reset mid-operation with queued entries and a credit outstanding
        ALU_RDY = 1'b0;
        EX_ALU_VLD = 1'b1;
        tick();
        EX_ALU_VLD = 1'b0;
        for (int i = 0; i < 3; i++) begin
            REQ_VLD = 1'b1; REQ_A = 8'(8'h31 + i);
            tick();
        end
        REQ_VLD = 1'b0;
        chk("pre_rst_cnt", 32'(FIFO_CNT), 32'd3);
        chk("pre_rst_out", 32'(OUTST),    32'd1);
        ALU_RDY = 1'b1;
        RST = 1'b1;
        #1;
        chk("in_rst_act", 32'(ACT),     32'd0);
        chk("in_rst_rdy", 32'(REQ_RDY), 32'd0);
        tick();
        chk("post_rst_cnt", 32'(FIFO_CNT), 32'd0);
        chk("post_rst_out", 32'(OUTST),    32'd0);
        chk("post_rst_act", 32'(ACT),      32'd0);
        RST = 1'b0;
        #1;
        chk("post_rst_rdy", 32'(REQ_RDY), 32'd1);

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            REQ_VLD    = ($urandom_range(0, 9) < 7);
            REQ_OP     = 4'($urandom);
            REQ_MOVI   = 2'($urandom);
            REQ_A      = 8'($urandom);
            REQ_B      = 8'($urandom);
            REQ_MEM    = 8'($urandom);
            REQ_IMM    = 8'($urandom);
            ALU_RDY    = ($urandom_range(0, 9) < 7);
            EX_ALU_VLD = ($urandom_range(0, 9) < 4);
            RST        = ($urandom_range(0, 199) == 0);
            tick();
        end
        RST = 1'b1;
        REQ_VLD = 1'b0;
        EX_ALU_VLD = 1'b0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
